// File: rtl/clock_set_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_controller_if
//  Description : Button inputs and counter-chain control outputs of the
//                time-of-day set controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface clock_set_controller_if;
    logic       btn_mode;
    logic       btn_adv;
    logic       seconds_tick;
    logic       set;
    logic       hour_up;
    logic       minute_up;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_adv,
        input  seconds_tick, set, hour_up, minute_up, mode, blink
    );

    modport slave (
        input  btn_mode, btn_adv,
        output seconds_tick, set, hour_up, minute_up, mode, blink
    );
endinterface
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_controller
//  Description : 1 Hz prescaler plus RUN/SET_HOUR/SET_MIN setting FSM.
//                Define AUTOREPEAT_EN to enable held-button auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_set_controller #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int TIMEOUT_S    = 30,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    clock_set_controller_if.slave bus
);

    localparam int c_presc_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_to_w    = (TIMEOUT_S > 2) ? $clog2(TIMEOUT_S) : 1;
    localparam int c_half    = TICK_DIV / 2;

    if (TICK_DIV < 2 || TIMEOUT_S < 0 || REPEAT_DELAY < 2 || REPEAT_RATE < 1) begin : g_bad_params
        $error("clock_set_controller: invalid parameter value");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_presc_w-1:0]   r_presc, w_presc_nxt;
    logic [c_to_w-1:0]      r_to, w_to_nxt;
    logic                   r_mode_prev, r_adv_prev;
    logic                   r_tick, w_tick_nxt;
    logic                   r_set, w_set_nxt;
    logic                   r_hour_up, w_hour_nxt;
    logic                   r_minute_up, w_minute_nxt;
    logic                   r_blink, w_blink_nxt;

    logic w_mode_press, w_adv_press, w_wrap, w_in_set, w_blink_tog, w_rep_pulse, w_up;

    assign w_mode_press = bus.btn_mode & ~r_mode_prev;
    assign w_adv_press  = bus.btn_adv & ~r_adv_prev;
    assign w_wrap       = (r_presc == c_presc_w'(TICK_DIV - 1));
    assign w_in_set     = (r_state != ST_RUN);
    assign w_blink_tog  = w_wrap || (r_presc == c_presc_w'(c_half - 1));

`ifdef AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_rep_w   = (c_rep_max > 2) ? $clog2(c_rep_max) : 1;

    logic               r_rep_active, r_rep_rate;
    logic [c_rep_w-1:0] r_rep_cnt;
    logic               w_rep_hit;

    // r_rep_cnt counts held samples; the delay phase includes the press sample
    assign w_rep_hit   = r_rep_rate ? (r_rep_cnt == c_rep_w'(REPEAT_RATE - 1))
                                    : (r_rep_cnt == c_rep_w'(REPEAT_DELAY - 1));
    assign w_rep_pulse = r_rep_active & bus.btn_adv & w_in_set & ~w_mode_press & w_rep_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_active <= 1'b0;
            r_rep_rate   <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_state_nxt != r_state || !bus.btn_adv) begin
            r_rep_active <= 1'b0;
        end else if (w_adv_press && w_in_set) begin
            r_rep_active <= 1'b1;
            r_rep_rate   <= 1'b0;
            r_rep_cnt    <= c_rep_w'(1);
        end else if (r_rep_active) begin
            if (w_rep_hit) begin
                r_rep_cnt  <= '0;
                r_rep_rate <= 1'b1;
            end else begin
                r_rep_cnt  <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = w_wrap ? '0 : r_presc + 1'b1;
        w_to_nxt     = r_to;
        w_tick_nxt   = 1'b0;
        w_hour_nxt   = 1'b0;
        w_minute_nxt = 1'b0;
        w_blink_nxt  = (w_in_set && w_blink_tog) ? ~r_blink : r_blink;
        w_up         = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mode_press) w_state_nxt = ST_SET_HOUR;
                else              w_tick_nxt  = w_wrap;
            end
            ST_SET_HOUR: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_SET_MIN;
                end else begin
                    w_up       = w_adv_press | w_rep_pulse;
                    w_hour_nxt = w_up;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_up         = w_adv_press | w_rep_pulse;
                    w_minute_nxt = w_up;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // An up-pulse restarts the idle count even on a wrap cycle
        if (w_in_set && w_state_nxt == r_state) begin
            if (w_up) begin
                w_to_nxt = '0;
            end else if (w_wrap && TIMEOUT_S != 0) begin
                if (r_to == c_to_w'(TIMEOUT_S - 1)) w_state_nxt = ST_RUN;
                else                                w_to_nxt    = r_to + 1'b1;
            end
        end

        if (w_state_nxt != r_state) begin
            w_presc_nxt = '0;
            w_to_nxt    = '0;
            w_blink_nxt = 1'b0;
        end

        w_set_nxt = (w_state_nxt != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_presc     <= '0;
            r_to        <= '0;
            r_mode_prev <= 1'b0;
            r_adv_prev  <= 1'b0;
            r_tick      <= 1'b0;
            r_set       <= 1'b0;
            r_hour_up   <= 1'b0;
            r_minute_up <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_to        <= w_to_nxt;
            r_mode_prev <= bus.btn_mode;
            r_adv_prev  <= bus.btn_adv;
            r_tick      <= w_tick_nxt;
            r_set       <= w_set_nxt;
            r_hour_up   <= w_hour_nxt;
            r_minute_up <= w_minute_nxt;
            r_blink     <= w_blink_nxt;
        end
    end

    assign bus.seconds_tick = r_tick;
    assign bus.set          = r_set;
    assign bus.hour_up      = r_hour_up;
    assign bus.minute_up    = r_minute_up;
    assign bus.mode         = r_state;
    assign bus.blink        = r_blink;

endmodule
`default_nettype wire
